// File: rtl/nn_accel_pkg.sv
// nn_accel_pkg: shared image geometry, result width and the row sender state type
package nn_accel_pkg;
    localparam int IMG_DIM     = 14;
    localparam int IMG_BITS    = IMG_DIM * IMG_DIM;
    localparam int ROW_CHUNK_W = 7;
    localparam int ROW_CHUNKS  = 28;
    localparam int BCD_W       = 4;
    typedef enum logic [1:0] {IDLE, SYNC, SEND, WAIT_RESULT} sender_state_t;
endpackage

// File: rtl/chunk_shifter.sv
// chunk_shifter: holds a loaded image and presents it one CHUNK_W slice at a time, LSBs first
module chunk_shifter #(
    parameter int CHUNK_W          = 7,
    parameter int NUM_CHUNKS       = 28,
    parameter int CYCLES_PER_CHUNK = 1,
    localparam int IMG_W           = CHUNK_W * NUM_CHUNKS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               advance,
    input  logic [IMG_W-1:0]   image_in,
    output logic [CHUNK_W-1:0] chunk,
    output logic               last_chunk
);
    localparam int CW = $clog2(NUM_CHUNKS + 1);
    localparam int PW = $clog2(CYCLES_PER_CHUNK + 1);
    logic [IMG_W-1:0] sr;
    logic [CW-1:0]    chunk_cnt;
    logic [PW-1:0]    pace_cnt;
    logic             chunk_done;
    assign chunk_done = pace_cnt == PW'(CYCLES_PER_CHUNK - 1);
    assign last_chunk = chunk_done && chunk_cnt == CW'(NUM_CHUNKS - 1);
    assign chunk      = sr[CHUNK_W-1:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            chunk_cnt <= '0;
            pace_cnt  <= '0;
        end else if (load) begin
            sr        <= image_in;
            chunk_cnt <= '0;
            pace_cnt  <= '0;
        end else if (advance) begin
            sr        <= chunk_done ? sr >> CHUNK_W : sr;
            chunk_cnt <= chunk_done ? chunk_cnt + CW'(1) : chunk_cnt;
            pace_cnt  <= chunk_done ? '0 : pace_cnt + PW'(1);
        end
    end
endmodule

// File: rtl/image_row_sender.sv
// image_row_sender: streams a loaded binary image as row chunks behind a frame-start strobe,
// then captures the accelerator's BCD result or flags a timeout.
module image_row_sender
    import nn_accel_pkg::*;
#(
    parameter int CHUNK_W          = ROW_CHUNK_W,
    parameter int NUM_CHUNKS       = ROW_CHUNKS,
    parameter int SYNC_CYCLES      = 2,
    parameter int CYCLES_PER_CHUNK = 1,
    parameter int RESULT_TIMEOUT   = 1023,
    localparam int IMG_W           = CHUNK_W * NUM_CHUNKS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [IMG_W-1:0]   image_in,
    output logic [CHUNK_W-1:0] data_out,
    output logic               frame_n,
    input  logic               result_valid,
    input  logic [BCD_W-1:0]   result_bcd,
    output logic [BCD_W-1:0]   digit_out,
    output logic               digit_valid,
    output logic               timeout,
    output logic               busy
);
    localparam int CNT_MAX = RESULT_TIMEOUT > SYNC_CYCLES ? RESULT_TIMEOUT : SYNC_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    sender_state_t      state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CHUNK_W-1:0] chunk;
    logic               last_chunk, sync_done, wait_done, got_result;
    assign sync_done  = cnt == CNT_W'(SYNC_CYCLES - 1);
    assign wait_done  = cnt == CNT_W'(RESULT_TIMEOUT - 1);
    assign got_result = state == WAIT_RESULT && result_valid;
    chunk_shifter #(
        .CHUNK_W(CHUNK_W),
        .NUM_CHUNKS(NUM_CHUNKS),
        .CYCLES_PER_CHUNK(CYCLES_PER_CHUNK)
    ) u_shifter (
        .clk(clk),
        .rst_n(rst_n),
        .load(state == IDLE && load_valid),
        .advance(state == SEND),
        .image_in(image_in),
        .chunk(chunk),
        .last_chunk(last_chunk)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:        state_n = load_valid ? SYNC : IDLE;
            SYNC:        state_n = sync_done ? SEND : SYNC;
            SEND:        state_n = last_chunk ? WAIT_RESULT : SEND;
            WAIT_RESULT: state_n = (result_valid || wait_done) ? IDLE : WAIT_RESULT;
        endcase
    end
    always_comb begin
        load_ready = state == IDLE;
        busy       = state != IDLE;
        frame_n    = state != SYNC;
        data_out   = state == SEND ? chunk : '0;
    end
    // One counter times both SYNC and WAIT_RESULT; it restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            digit_out   <= '0;
            digit_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            cnt         <= (state_n != state || state == IDLE) ? '0 : cnt + CNT_W'(1);
            digit_out   <= got_result ? result_bcd : digit_out;
            digit_valid <= got_result;
            timeout     <= state == WAIT_RESULT && !result_valid && wait_done;
        end
    end
endmodule

// File: tb/tb_image_row_sender.sv
// tb_image_row_sender: randomized frames on two parameterisations checked against a frame-level model
module tb_image_row_sender;
    localparam int SYNC = 2;
    localparam int NCH  = 28;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid[2];
    logic       load_ready[2];
    logic [195:0] image_in[2];
    logic [6:0] data_out[2];
    logic       frame_n[2];
    logic       result_valid[2];
    logic [3:0] result_bcd[2];
    logic [3:0] digit_out[2];
    logic       digit_valid[2];
    logic       timeout[2];
    logic       busy[2];
    logic [3:0] exp_digit[2];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        image_row_sender #(
            .SYNC_CYCLES(SYNC),
            .CYCLES_PER_CHUNK(g == 0 ? 1 : 3),
            .RESULT_TIMEOUT(g == 0 ? 1023 : 8)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .load_valid(load_valid[g]),
            .load_ready(load_ready[g]),
            .image_in(image_in[g]),
            .data_out(data_out[g]),
            .frame_n(frame_n[g]),
            .result_valid(result_valid[g]),
            .result_bcd(result_bcd[g]),
            .digit_out(digit_out[g]),
            .digit_valid(digit_valid[g]),
            .timeout(timeout[g]),
            .busy(busy[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int cpc(input int d);
        return d == 0 ? 1 : 3;
    endfunction

    function automatic int tmo(input int d);
        return d == 0 ? 1023 : 8;
    endfunction

    function automatic logic [195:0] rand_img();
        logic [195:0] v;
        for (int i = 0; i < 196; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // Called and returning at a negedge with the DUT idle. rdly < 0 means no result (timeout).
    task automatic run_frame(input int d, input logic [195:0] img, input int rdly,
                             input logic [3:0] bcd, input bit noise);
        int wlen;
        chk("idle_ready", load_ready[d], 1);
        chk("idle_busy", busy[d], 0);
        load_valid[d] = 1'b1;
        image_in[d]   = img;
        for (int s = 0; s < SYNC; s++) begin
            @(negedge clk);
            load_valid[d]   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            image_in[d]     = noise ? ~img : img;
            result_valid[d] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            result_bcd[d]   = 4'($urandom);
            chk("sync_frame_n", frame_n[d], 0);
            chk("sync_data", data_out[d], 0);
            chk("sync_busy", busy[d], 1);
            chk("sync_ready", load_ready[d], 0);
        end
        for (int k = 0; k < NCH; k++) begin
            for (int c = 0; c < cpc(d); c++) begin
                @(negedge clk);
                load_valid[d]   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                result_valid[d] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                result_bcd[d]   = 4'($urandom);
                chk("send_frame_n", frame_n[d], 1);
                chk($sformatf("send_chunk%0d", k), data_out[d], 32'(img[7*k +: 7]));
                chk("send_busy", busy[d], 1);
                chk("send_ready", load_ready[d], 0);
            end
        end
        wlen = rdly < 0 ? tmo(d) : rdly + 1;
        for (int w = 0; w < wlen; w++) begin
            @(negedge clk);
            load_valid[d]   = 1'b0;
            result_valid[d] = w == rdly;
            result_bcd[d]   = bcd;
            chk("wait_data", data_out[d], 0);
            chk("wait_busy", busy[d], 1);
            chk("wait_dvalid", digit_valid[d], 0);
            chk("wait_timeout", timeout[d], 0);
        end
        if (rdly >= 0) exp_digit[d] = bcd;
        @(negedge clk);
        result_valid[d] = 1'b0;
        chk("end_dvalid", digit_valid[d], 32'(rdly >= 0));
        chk("end_timeout", timeout[d], 32'(rdly < 0));
        chk("end_digit", digit_out[d], exp_digit[d]);
        chk("end_ready", load_ready[d], 1);
        chk("end_busy", busy[d], 0);
        @(negedge clk);
        chk("post_dvalid", digit_valid[d], 0);
        chk("post_timeout", timeout[d], 0);
        chk("post_digit", digit_out[d], exp_digit[d]);
    endtask

    initial begin
        logic [195:0] a, b;
        for (int d = 0; d < 2; d++) begin
            load_valid[d] = 1'b0;
            image_in[d] = '0;
            result_valid[d] = 1'b0;
            result_bcd[d] = '0;
            exp_digit[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_data", data_out[d], 0);
            chk("rst_frame_n", frame_n[d], 1);
            chk("rst_ready", load_ready[d], 1);
            chk("rst_digit", digit_out[d], 0);
            chk("rst_dvalid", digit_valid[d], 0);
            chk("rst_timeout", timeout[d], 0);
            chk("rst_busy", busy[d], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        a = {98{2'b01}};
        run_frame(0, a, 5, 4'd7, 1'b0);
        run_frame(1, 196'd1, 0, 4'd3, 1'b0);
        run_frame(1, rand_img(), -1, 4'd0, 1'b0);
        run_frame(1, rand_img(), 7, 4'd9, 1'b0);
        a = rand_img();
        run_frame(0, a, 2, 4'd4, 1'b1);
        run_frame(0, ~a, 0, 4'd1, 1'b0);
        b = rand_img();
        load_valid[0] = 1'b1;
        image_in[0] = b;
        repeat (1 + SYNC + 10) begin
            @(negedge clk);
            load_valid[0] = 1'b0;
        end
        chk("pre_rst_chunk10", data_out[0], 32'(b[70 +: 7]));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_data", data_out[0], 0);
        chk("async_rst_frame_n", frame_n[0], 1);
        chk("async_rst_busy", busy[0], 0);
        chk("async_rst_ready", load_ready[0], 1);
        chk("async_rst_digit", digit_out[0], 0);
        exp_digit[0] = '0;
        exp_digit[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(0, rand_img(), 3, 4'd5, 1'b0);
        for (int i = 0; i < 4; i++)
            run_frame(i % 2, rand_img(), $urandom_range(0, 6), 4'($urandom_range(0, 9)), 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
